ysyx_220066_mem_stage: RTL and testbench

YSYX_220066_MEM_STAGE -- requirements
Module: ysyx_220066_mem_stage

---
 rtl/ysyx_220066_mem_stage_if.sv | 20 ++
 rtl/ysyx_220066_mem_stage.sv | 124 ++++++++++++
 tb/tb_ysyx_220066_mem_stage.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_mem_stage_if.sv
// ysyx_220066_mem_stage_if: data-memory bus between the memory stage and memory
interface ysyx_220066_mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata, mem_err
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/ysyx_220066_mem_stage.sv
// ysyx_220066_mem_stage: memory pipeline stage with req/ready bus and load extraction
module ysyx_220066_mem_stage (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           busy,
  input  logic [63:0]                    result_in,
  input  logic [63:0]                    data_wr_in,
  input  logic [7:0]                     wmask_in,
  input  logic [2:0]                     MemOp_in,
  input  logic                           MemRd_in,
  input  logic                           MemWr_in,
  input  logic                           RegWr_in,
  input  logic [4:0]                     rd_in,
  input  logic [63:0]                    pc_in,
  ysyx_220066_mem_stage_if.master        mem,
  input  logic                           block_in,
  output logic                           valid,
  output logic [4:0]                     rd,
  output logic                           RegWr,
  output logic [63:0]                    wb_data,
  output logic [63:0]                    pc,
  output logic                           error
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, pc_q, pc_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  memop_q, memop_d;
  logic [4:0]  rd_q, rd_d;
  logic        memrd_q, memrd_d, memwr_q, memwr_d, regwr_q, regwr_d, error_q, error_d;
  logic        accept, mem_op, misaligned, resp;
  logic [63:0] lane, load_data;
  assign busy       = ~(state_q == IDLE || (state_q == DONE && ~block_in));
  assign accept     = valid_in && ~busy;
  assign mem_op     = MemRd_in || MemWr_in;
  assign misaligned = MemOp_in[1:0] == 2'd1 ? result_in[0]
                    : MemOp_in[1:0] == 2'd2 ? |result_in[1:0]
                    : MemOp_in[1:0] == 2'd3 ? |result_in[2:0] : 1'b0;
  // a response only counts once the request has been handed over to memory
  assign resp       = mem.mem_rvalid && (state_q == WAIT || (state_q == REQ && mem.mem_ready));
  assign lane       = mem.mem_rdata >> {addr_q[2:0], 3'b000};
  assign load_data  = memop_q[1:0] == 2'd0 ? {{56{~memop_q[2] & lane[7]}}, lane[7:0]}
                    : memop_q[1:0] == 2'd1 ? {{48{~memop_q[2] & lane[15]}}, lane[15:0]}
                    : memop_q[1:0] == 2'd2 ? {{32{~memop_q[2] & lane[31]}}, lane[31:0]} : lane;
  assign mem.mem_req   = state_q == REQ;
  assign mem.mem_we    = state_q == REQ && memwr_q;
  assign mem.mem_addr  = {addr_q[63:3], 3'b000};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = memwr_q ? wmask_q : 8'h00;
  assign valid   = state_q == DONE;
  assign rd      = rd_q;
  assign pc      = pc_q;
  assign wb_data = wb_data_q;
  assign error   = error_q;
  assign RegWr   = valid && regwr_q && ~error_q;
  // next state: capture on accept, complete on response, drain DONE when not blocked
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    memop_d   = memop_q;
    memrd_d   = memrd_q;
    memwr_d   = memwr_q;
    regwr_d   = regwr_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    wb_data_d = wb_data_q;
    error_d   = error_q;
    if (accept) begin
      addr_d    = result_in;
      wdata_d   = data_wr_in;
      wmask_d   = wmask_in;
      memop_d   = MemOp_in;
      memrd_d   = MemRd_in;
      memwr_d   = MemWr_in;
      regwr_d   = RegWr_in;
      rd_d      = rd_in;
      pc_d      = pc_in;
      wb_data_d = result_in;
      error_d   = mem_op && misaligned;
      state_d   = mem_op && ~misaligned ? REQ : DONE;
    end else if (state_q == DONE && ~block_in) begin
      state_d = IDLE;
    end else if (resp) begin
      state_d   = DONE;
      wb_data_d = memrd_q ? load_data : addr_q;
      error_d   = mem.mem_err;
    end else if (state_q == REQ && mem.mem_ready) begin
      state_d = WAIT;
    end
  end
  // state and captured-instruction registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      memop_q   <= '0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      regwr_q   <= 1'b0;
      rd_q      <= '0;
      pc_q      <= '0;
      wb_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      memop_q   <= memop_d;
      memrd_q   <= memrd_d;
      memwr_q   <= memwr_d;
      regwr_q   <= regwr_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      wb_data_q <= wb_data_d;
      error_q   <= error_d;
    end
  end
endmodule

// File: tb/tb_ysyx_220066_mem_stage.sv
// tb_ysyx_220066_mem_stage: randomized bench with behavioural reference model
module tb_ysyx_220066_mem_stage;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic        valid_in, busy, MemRd_in, MemWr_in, RegWr_in, block_in, valid, RegWr, error;
  logic [63:0] result_in, data_wr_in, pc_in, wb_data, pc;
  logic [7:0]  wmask_in;
  logic [2:0]  MemOp_in;
  logic [4:0]  rd_in, rd;
  ysyx_220066_mem_stage_if mif ();
  ysyx_220066_mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .busy(busy), .result_in(result_in),
    .data_wr_in(data_wr_in), .wmask_in(wmask_in), .MemOp_in(MemOp_in), .MemRd_in(MemRd_in),
    .MemWr_in(MemWr_in), .RegWr_in(RegWr_in), .rd_in(rd_in), .pc_in(pc_in), .mem(mif),
    .block_in(block_in), .valid(valid), .rd(rd), .RegWr(RegWr), .wb_data(wb_data),
    .pc(pc), .error(error)
  );
  typedef struct {
    logic [63:0] res, wdata, pc;
    logic [7:0]  wmask;
    logic [2:0]  mop;
    logic        r, w, regwr;
    logic [4:0]  rd;
  } op_t;
  typedef struct {
    logic [63:0] wb, pc, addr, wdata;
    logic [7:0]  wmask;
    logic [4:0]  rd;
    logic        err, regwr, req, we, hs, seen;
    int          done_cyc;
  } exp_t;
  localparam int NEVER = 32'h3fff_ffff;
  int   n_cmp = 0, n_fail = 0, cyc = 0;
  exp_t exp_q[$];
  op_t  cur_op;
  logic resp_en = 1'b1, man_ready = 1'b0, man_rvalid = 1'b0;
  logic ovr_en = 1'b0, ovr_err = 1'b0, fixed_en = 1'b0, spur_en = 1'b0, rand_blk = 1'b0;
  logic [63:0] ovr_data = '0;
  int   fixed_r = 0, fixed_v = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask
  function automatic logic [63:0] word(input logic [63:0] a);
    return {a[31:0] * 32'h9E3779B1, ~a[31:0] ^ 32'h5A5A0F0F};
  endfunction
  function automatic logic err_of(input logic [63:0] a);
    return a[6:3] == 4'hB;
  endfunction
  // expected architectural result of one accepted instruction
  function automatic exp_t model(input op_t o, input int c);
    exp_t m;
    logic [63:0] data, sh, mask, v;
    int nb;
    logic mis, memop;
    memop = o.r || o.w;
    mis = (o.res & ((64'd1 << o.mop[1:0]) - 64'd1)) != 0;
    m.req = memop && !mis;
    m.addr = o.res & ~64'h7;
    m.we = o.w;
    m.wdata = o.wdata;
    m.wmask = o.w ? o.wmask : 8'h00;
    m.err = m.req ? (ovr_en ? ovr_err : err_of(m.addr)) : (memop && mis);
    data = ovr_en ? ovr_data : word(m.addr);
    nb = 8 << o.mop[1:0];
    sh = data >> (8 * o.res[2:0]);
    mask = nb == 64 ? '1 : (64'd1 << nb) - 64'd1;
    v = sh & mask;
    if (!o.mop[2] && nb < 64 && v[nb-1]) v = v | ~mask;
    m.wb = (m.req && o.r) ? v : o.res;
    m.regwr = o.regwr && !m.err;
    m.rd = o.rd;
    m.pc = o.pc;
    m.hs = 1'b0;
    m.seen = 1'b0;
    m.done_cyc = m.req ? NEVER : c + 1;
    return m;
  endfunction
  function automatic op_t mk(input logic r, input logic w, input logic [2:0] mop,
                             input logic [63:0] res, input logic regwr, input logic [4:0] rdn,
                             input logic [7:0] wm);
    op_t o;
    o.r = r; o.w = w; o.mop = mop; o.res = res; o.regwr = regwr; o.rd = rdn; o.wmask = wm;
    o.wdata = {$urandom, $urandom};
    o.pc = {32'h0, $urandom};
    return o;
  endfunction
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // memory responder: random or fixed ready/response delays, optional stray rvalids
  initial begin
    int phase, rcnt, vcnt;
    logic [63:0] raddr;
    phase = 0; rcnt = 0; vcnt = 0; raddr = '0;
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_err = 1'b0; mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_err = 1'b0;
      mif.mem_rdata = {$urandom, $urandom};
      if (!resp_en) begin
        mif.mem_ready = man_ready; mif.mem_rvalid = man_rvalid; mif.mem_rdata = ovr_data;
        phase = 0;
      end else if (!rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && mif.mem_req) begin
          phase = 1;
          raddr = mif.mem_addr;
          rcnt = fixed_en ? fixed_r : int'($urandom % 4);
          vcnt = fixed_en ? fixed_v : int'($urandom % 4);
        end
        if (phase == 1) begin
          if (rcnt == 0) begin
            mif.mem_ready = 1'b1;
            phase = 2;
          end else rcnt--;
        end else if (phase == 2) begin
          vcnt--;
        end else if (spur_en && $urandom % 6 == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_err = 1'($urandom % 2);
        end
        if (phase == 2 && vcnt <= 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata = ovr_en ? ovr_data : word(raddr);
          mif.mem_err = ovr_en ? ovr_err : err_of(raddr);
          phase = 0;
        end
      end
    end
  end
  // compare process: every cycle, DUT outputs against the model queue
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) exp_q.delete();
    else begin
      if (valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 64'(valid), 64'(0));
        else begin
          e = exp_q[0];
          chk("wb_data", wb_data, e.wb);
          chk("rd", 64'(rd), 64'(e.rd));
          chk("pc", pc, e.pc);
          chk("error", 64'(error), 64'(e.err));
          chk("RegWr", 64'(RegWr), 64'(e.regwr));
          if (!e.seen) chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          e.seen = 1'b1;
          exp_q[0] = e;
          if (!block_in) void'(exp_q.pop_front());
        end
        chk("busy_done", 64'(busy), 64'(block_in));
      end else chk(exp_q.size() != 0 ? "busy_in_flight" : "busy_idle", 64'(busy), 64'(exp_q.size() != 0));
      if (mif.mem_req) begin
        if (exp_q.size() == 0 || !exp_q[0].req || valid) chk("spurious_req", 64'(mif.mem_req), 64'(0));
        else begin
          e = exp_q[0];
          chk("mem_addr", mif.mem_addr, e.addr);
          chk("mem_we", 64'(mif.mem_we), 64'(e.we));
          chk("mem_wdata", mif.mem_wdata, e.wdata);
          chk("mem_wmask", 64'(mif.mem_wmask), 64'(e.wmask));
        end
      end
      if (exp_q.size() != 0 && !valid) begin
        e = exp_q[0];
        if (e.req && e.done_cyc == NEVER) begin
          if (mif.mem_req && mif.mem_ready) e.hs = 1'b1;
          if (e.hs && mif.mem_rvalid) e.done_cyc = cyc + 1;
          exp_q[0] = e;
        end
      end
      if (valid_in && !busy) exp_q.push_back(model(cur_op, cyc));
    end
  end
  task automatic drive(input op_t o);
    cur_op = o;
    result_in = o.res; data_wr_in = o.wdata; wmask_in = o.wmask; MemOp_in = o.mop;
    MemRd_in = o.r; MemWr_in = o.w; RegWr_in = o.regwr; rd_in = o.rd; pc_in = o.pc;
    valid_in = 1'b1;
  endtask
  task automatic issue(input op_t o);
    @(posedge clk);
    #1;
    drive(o);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) return;
      @(posedge clk);
      #1;
      if (rand_blk) block_in = ($urandom % 3 == 0);
    end
    chk("accept_timeout", 64'(busy), 64'(0));
    valid_in = 1'b0;
  endtask
  task automatic wait_sig(input bit want_req);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      @(negedge clk);
      if (want_req ? mif.mem_req : valid) return;
    end
    chk(want_req ? "req_timeout" : "valid_timeout", 64'(want_req ? mif.mem_req : valid), 64'(1));
  endtask
  initial begin
    op_t o;
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    op_t o;
    valid_in = 0; block_in = 0; result_in = 0; data_wr_in = 0; wmask_in = 0; MemOp_in = 0;
    MemRd_in = 0; MemWr_in = 0; RegWr_in = 0; rd_in = 0; pc_in = 0;
    cur_op = mk(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(valid), 0); chk("rst_req", 64'(mif.mem_req), 0);
    chk("rst_error", 64'(error), 0); chk("rst_RegWr", 64'(RegWr), 0);
    chk("rst_wb", wb_data, 0); chk("rst_rd", 64'(rd), 0);
    chk("rst_pc", pc, 0); chk("rst_busy", 64'(busy), 0);
    issue(mk(0, 0, 3'b000, 64'h1234, 1, 5'd5, 8'h00));
    wait_sig(0);
    chk("alu_wb", wb_data, 64'h1234); chk("alu_rd", 64'(rd), 64'd5); chk("alu_RegWr", 64'(RegWr), 64'd1);
    ovr_en = 1; ovr_err = 0; ovr_data = 64'h00000000_80FF0000;
    issue(mk(1, 0, 3'b000, 64'h80000003, 1, 5'd6, 8'h00));
    wait_sig(0);
    chk("lb_wb", wb_data, 64'hFFFFFFFFFFFFFF80);
    issue(mk(1, 0, 3'b100, 64'h80000003, 1, 5'd6, 8'h00));
    wait_sig(0);
    chk("lbu_wb", wb_data, 64'h80);
    fixed_en = 1; fixed_r = 3; fixed_v = 2; ovr_data = 64'h80000001_12345678;
    issue(mk(1, 0, 3'b010, 64'h80000004, 1, 5'd7, 8'h00));
    wait_sig(1);
    chk("lw_addr", mif.mem_addr, 64'h80000000);
    wait_sig(0);
    chk("lw_wb", wb_data, 64'hFFFFFFFF80000001);
    fixed_en = 0;
    issue(mk(0, 1, 3'b011, 64'h80000008, 0, 5'd0, 8'hFF));
    wait_sig(1);
    chk("sd_we", 64'(mif.mem_we), 64'd1); chk("sd_wmask", 64'(mif.mem_wmask), 64'hFF);
    wait_sig(0);
    chk("sd_error", 64'(error), 0);
    issue(mk(1, 0, 3'b001, 64'h80000001, 1, 5'd8, 8'h00));
    wait_sig(0);
    chk("lh_mis_error", 64'(error), 64'd1); chk("lh_mis_RegWr", 64'(RegWr), 0);
    @(posedge clk);
    #1 block_in = 1'b1;
    issue(mk(0, 0, 3'b000, 64'hAAAA, 1, 5'd9, 8'h00));
    @(posedge clk);
    #1 drive(mk(0, 0, 3'b000, 64'hBBBB, 1, 5'd10, 8'h00));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blk_busy", 64'(busy), 64'd1); chk("blk_valid", 64'(valid), 64'd1);
      chk("blk_wb", wb_data, 64'hAAAA);
      @(posedge clk);
      #1;
    end
    block_in = 1'b0;
    @(negedge clk);
    chk("release_accept", 64'(busy), 0);
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(valid), 64'd1); chk("b2b_wb", wb_data, 64'hBBBB);
    resp_en = 0; ovr_data = 64'hDEADBEEF_CAFEF00D;
    issue(mk(1, 0, 3'b011, 64'h80000010, 1, 5'd11, 8'h00));
    wait_sig(1);
    @(posedge clk);
    #1 man_ready = 1;
    @(posedge clk);
    #1 man_ready = 0; rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; man_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstw_valid", 64'(valid), 0); chk("rstw_req", 64'(mif.mem_req), 0);
      chk("rstw_busy", 64'(busy), 0); chk("rstw_wb", wb_data, 0); chk("rstw_rd", 64'(rd), 0);
      @(posedge clk);
      #1;
    end
    man_rvalid = 0; resp_en = 1; ovr_en = 0; spur_en = 1; rand_blk = 1;
    for (int n = 0; n < 1500; n++) begin
      int k;
      logic [2:0] mop;
      logic [63:0] res;
      k = int'($urandom % 10);
      mop = 3'($urandom);
      res = k < 3 ? {$urandom, $urandom} : {32'h0, 32'h80000000 | ($urandom & 32'h3FF)};
      if (k >= 3 && $urandom % 4 != 0) res = res & ~((64'd1 << mop[1:0]) - 64'd1);
      o = mk(k >= 3 && k < 7, k >= 7, mop, res, 1'($urandom), 5'($urandom), 8'($urandom));
      if ($urandom % 2 == 0) begin
        repeat ($urandom % 3) begin
          @(posedge clk);
          #1 valid_in = 1'b0; block_in = ($urandom % 3 == 0);
        end
      end
      issue(o);
    end
    rand_blk = 0;
    @(posedge clk);
    #1 valid_in = 1'b0; block_in = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
